width_128to24: RTL and testbench

WIDTH_128TO24 -- requirements
Module: width_128to24

---
 rtl/width_128to24_pkg.sv | 21 ++
 rtl/width_128to24.sv | 70 +++++++
 tb/tb_width_128to24.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/width_128to24_pkg.sv
// Shared width constants for the 128<->24 bit stream width converters.
// Both the 24-to-128 packer and the 128-to-24 unpacker import this package
// so that the buffer and counter sizes stay in step.
package width_128to24_pkg;

    localparam int IN_W  = 128;
    localparam int OUT_W = 24;
    localparam int BUF_W = 152;
    localparam int CNT_W = 8;

    // Counter-width copies of the word sizes, used for buf_bits arithmetic
    localparam logic [CNT_W-1:0] IN_CNT      = 8'd128;
    localparam logic [CNT_W-1:0] OUT_CNT     = 8'd24;
    localparam logic [CNT_W-1:0] TWO_OUT_CNT = 8'd48;

    // Place a wide input word at the top of an empty buffer-wide vector
    function automatic logic [BUF_W-1:0] align_in_word(input logic [IN_W-1:0] word);
        return {word, {(BUF_W-IN_W){1'b0}}};
    endfunction

endpackage

// File: rtl/width_128to24.sv
// Width converter: unpacks a stream of 128-bit words into a stream of
// 24-bit words, MSB first, with valid/ready handshakes on both sides.
// Bits are held in an MSB-aligned buffer; every bit below the valid
// region is kept at zero so new words can simply be OR-ed in.
module width_128to24
    import width_128to24_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    output logic                ready_in,
    input  logic [IN_W-1:0]     data_in,
    output logic                valid_out,
    input  logic                ready_out,
    output logic [OUT_W-1:0]    data_out,
    output logic [CNT_W-1:0]    buf_bits
);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_next;
    logic [BUF_W-1:0] buf_shifted;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_after_out;
    logic             valid_q;
    logic             in_fire;
    logic             out_fire;

    assign valid_out = valid_q;
    assign data_out  = buf_q[BUF_W-1 -: OUT_W];
    assign buf_bits  = cnt_q;

    // A word can be taken when it still fits after this cycle's possible
    // output shift; this keeps the count at or below 151 at all times.
    assign ready_in = (cnt_q < OUT_CNT) || ((cnt_q < TWO_OUT_CNT) && ready_out);
    assign in_fire  = valid_in && ready_in;
    assign out_fire = valid_q && ready_out;

    // Next buffer contents: drop the emitted slice first, then append the
    // incoming word directly below whatever valid bits remain.
    always_comb begin
        buf_shifted   = buf_q;
        cnt_after_out = cnt_q;
        if (out_fire) begin
            buf_shifted   = buf_q << OUT_W;
            cnt_after_out = cnt_q - OUT_CNT;
        end
        buf_next = buf_shifted;
        cnt_next = cnt_after_out;
        if (in_fire) begin
            buf_next = buf_shifted | (align_in_word(data_in) >> cnt_after_out);
            cnt_next = cnt_after_out + IN_CNT;
        end
    end

    // Buffer, bit counter and output-valid flag all update together; the
    // valid flag is registered so valid_out has no combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_next;
            cnt_q   <= cnt_next;
            valid_q <= (cnt_next >= OUT_CNT);
        end
    end

endmodule

// File: tb/tb_width_128to24.sv
// Self-checking bench for width_128to24. The reference model is a plain
// bit queue: accepted words are pushed MSB first, emitted words are popped
// 24 bits at a time, and the DUT outputs are compared against it each cycle.
module tb_width_128to24;
    import width_128to24_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               valid_in;
    logic               ready_in;
    logic [IN_W-1:0]    data_in;
    logic               valid_out;
    logic               ready_out;
    logic [OUT_W-1:0]   data_out;
    logic [CNT_W-1:0]   buf_bits;

    int checks   = 0;
    int failures = 0;

    bit              model_q[$];
    logic [23:0]     last_data;
    logic            last_ready;
    bit              last_out;
    bit              last_in;

    width_128to24 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .buf_bits  (buf_bits)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [23:0] modelTop();
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 24; i++) r[23-i] = model_q[i];
        return r;
    endfunction

    function automatic logic [127:0] randWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive inputs, check DUT against the model, then
    // advance the model by whatever transfers the handshake rules allow.
    task automatic applyStimulus(input logic vin, input logic [127:0] din, input logic rout);
        int   n;
        logic exp_valid;
        logic exp_ready;
        @(negedge clk);
        valid_in  = vin;
        data_in   = din;
        ready_out = rout;
        #1;
        n         = model_q.size();
        exp_valid = (n >= 24);
        exp_ready = (n < 24) || ((n < 48) && rout);
        checkOutput("buf_bits", buf_bits, n);
        checkOutput("valid_out", valid_out, exp_valid);
        checkOutput("ready_in", ready_in, exp_ready);
        checkOutput("buf_max", (buf_bits <= 8'd151), 1'b1);
        if (exp_valid) checkOutput("data_out", data_out, modelTop());
        last_data  = data_out;
        last_ready = ready_in;
        last_out   = exp_valid && rout;
        last_in    = vin && exp_ready;
        if (last_out) repeat (24) void'(model_q.pop_front());
        if (last_in) for (int i = 127; i >= 0; i--) model_q.push_back(din[i]);
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
    endtask

    // Pulse reset for one cycle and check the reset values while it is low
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_buf_bits", buf_bits, 0);
        checkOutput("rst_valid_out", valid_out, 0);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_ready_in", ready_in, 1);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic peekIdle(input string tag, input int exp_bits, input logic exp_valid);
        @(negedge clk);
        #1;
        checkOutput({tag, "_bits"}, buf_bits, exp_bits);
        checkOutput({tag, "_valid"}, valid_out, exp_valid);
    endtask

    logic [127:0] w0, w1, w2;
    logic [23:0]  exp_seq[5];
    logic [23:0]  frozen_data;
    logic [127:0] words[3];
    logic [127:0] pend;
    int           idx, outs, first_c, last_c, sent;
    bit           pending;

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        data_in   = '0;
        w0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        w1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        repeat (2) @(posedge clk);
        doReset();

        // Directed first word: five outputs, 8 bits left behind
        applyStimulus(1'b1, w0, 1'b1);
        checkOutput("w0_accept", last_in, 1);
        exp_seq = '{24'h001122, 24'h334455, 24'h667788, 24'h99AABB, 24'hCCDDEE};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("w0_out%0d", i), last_data, exp_seq[i]);
        end
        peekIdle("w0_residual", 8, 1'b0);

        // Directed second word crossing the word boundary
        applyStimulus(1'b1, w1, 1'b1);
        exp_seq = '{24'hFF0123, 24'h456789, 24'hABCDEF, 24'hFEDCBA, 24'h987654};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("w1_out%0d", i), last_data, exp_seq[i]);
        end
        peekIdle("w1_residual", 16, 1'b0);

        // Reset with residual bits: new word must start a fresh group
        doReset();
        w2 = randWord();
        applyStimulus(1'b1, w2, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_reset_first", last_data, w2[127:104]);
        checkOutput("post_reset_fire", last_out, 1);

        // Back-to-back group of three words with the sink always ready
        doReset();
        for (int i = 0; i < 3; i++) words[i] = randWord();
        idx = 0; outs = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && (idx < 3 || model_q.size() >= 24); c++) begin
            applyStimulus(idx < 3, (idx < 3) ? words[idx] : 128'h0, 1'b1);
            if (last_in) idx++;
            if (last_out) begin
                outs++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        checkOutput("stream_outputs", outs, 16);
        checkOutput("stream_span", last_c - first_c, 15);
        peekIdle("stream_end", 0, 1'b0);

        // Backpressure: sink stalls for five cycles with a word waiting
        doReset();
        applyStimulus(1'b1, randWord(), 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        frozen_data = modelTop();
        pend = randWord();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, pend, 1'b0);
            checkOutput("stall_data", last_data, frozen_data);
            checkOutput("stall_ready", last_ready, 0);
        end
        pending = 1'b1;
        for (int c = 0; c < 40 && (pending || model_q.size() >= 24); c++) begin
            applyStimulus(pending, pend, 1'b1);
            if (last_in) pending = 1'b0;
        end
        checkOutput("stall_drained", pending, 0);

        // Random handshakes over 3000 words
        doReset();
        sent = 0;
        pend = randWord();
        for (int c = 0; c < 80000 && sent < 3000; c++) begin
            applyStimulus(logic'($urandom_range(0, 1)), pend, logic'($urandom_range(0, 1)));
            if (last_in) begin
                sent++;
                pend = randWord();
            end
        end
        checkOutput("rand_words_sent", sent, 3000);
        for (int c = 0; c < 400 && model_q.size() >= 24; c++) applyStimulus(1'b0, '0, 1'b1);
        peekIdle("rand_end", model_q.size(), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
